// File: rtl/mips_cpu_regfile_write_arbiter_if.sv
// Writeback bus between the ALU/load sources, decode and the register file write port.
// The arbiter connects through the slave modport; sources, decode and the register file use master.
interface mips_cpu_regfile_write_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic [4:0]        alu_reg;
    logic [31:0]       alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [4:0]        mem_reg;
    logic [31:0]       mem_data;
    logic              mem_ready;
    logic [4:0]        read_reg_1;
    logic [4:0]        read_reg_2;
    logic              rf_write_enable;
    logic [4:0]        rf_write_reg;
    logic [31:0]       rf_write_data;
    logic              hazard_stall;
    logic [CNT_W-1:0]  queue_count;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
               read_reg_1, read_reg_2,
        input  alu_ready, mem_ready, rf_write_enable, rf_write_reg, rf_write_data,
               hazard_stall, queue_count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
               read_reg_1, read_reg_2,
        output alu_ready, mem_ready, rf_write_enable, rf_write_reg, rf_write_data,
               hazard_stall, queue_count
    );
endinterface

// File: rtl/mips_cpu_regfile_write_arbiter.sv
// Merges ALU and load writebacks into an in-order queue retiring one register-file write per cycle,
// and flags decode when a queued write targets a source register.
module mips_cpu_regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input logic                             clk,
    input logic                             reset,
    mips_cpu_regfile_write_arbiter_if.slave wb
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [4:0]       entry_reg  [DEPTH];
    logic [31:0]      entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PTR_W-1:0] head, tail, alu_slot, tail_next;
    logic [CNT_W-1:0] count, free, count_next;
    logic             pop, retire, mem_push, alu_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // free counts the slot released by this cycle's pop, so a full queue still takes one push.
    always_comb begin
        pop          = (count != '0);
        free         = DEPTH_C - count + (pop ? CNT_W'(1) : '0);
        wb.mem_ready = !reset && (free >= CNT_W'(1));
        wb.alu_ready = !reset && (wb.mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));
        mem_push     = wb.mem_valid && wb.mem_ready && (wb.mem_reg != 5'd0);
        alu_push     = wb.alu_valid && wb.alu_ready && (wb.alu_reg != 5'd0);
        alu_slot     = mem_push ? ptr_inc(tail) : tail;
        tail_next    = alu_push ? ptr_inc(alu_slot) : alu_slot;
        count_next   = count - (pop ? CNT_W'(1) : '0)
                     + (mem_push ? CNT_W'(1) : '0) + (alu_push ? CNT_W'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // Pop clears before pushes set, so a push into the slot just popped stays valid.
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= ptr_inc(head);
            end
            if (mem_push) entry_valid[tail]     <= 1'b1;
            if (alu_push) entry_valid[alu_slot] <= 1'b1;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            entry_reg[tail]  <= wb.mem_reg;
            entry_data[tail] <= wb.mem_data;
        end
        if (alu_push) begin
            entry_reg[alu_slot]  <= wb.alu_reg;
            entry_data[alu_slot] <= wb.alu_data;
        end
    end

    // Gating with reset keeps a discarded head from being written during the reset cycle.
    always_comb begin
        retire             = pop && !reset;
        wb.rf_write_enable = retire;
        wb.rf_write_reg    = retire ? entry_reg[head]  : 5'd0;
        wb.rf_write_data   = retire ? entry_data[head] : 32'd0;
        wb.queue_count     = count;
        wb.hazard_stall    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_reg[i] != 5'd0) &&
                ((entry_reg[i] == wb.read_reg_1) || (entry_reg[i] == wb.read_reg_2)))
                wb.hazard_stall = 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_no_zero_entry
        a_no_zero_reg: assert property (@(posedge clk) disable iff (reset)
            entry_valid[g] |-> (entry_reg[g] != 5'd0));
    end
endmodule
